// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: single-cycle logic/arithmetic, bit-serial shifts and a
// serial lowest-difference scan, with a registered result, flags and a one-cycle done pulse.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_control_input,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b1000;
  localparam logic [3:0] OP_COMP  = 4'b0001;
  localparam logic [3:0] OP_COMPI = 4'b1001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b1100;
  localparam logic [3:0] OP_SRL   = 4'b1101;
  localparam logic [3:0] OP_SRA   = 4'b1110;
  localparam logic [3:0] OP_SLLV  = 4'b0100;
  localparam logic [3:0] OP_SRLV  = 4'b0101;
  localparam logic [3:0] OP_SRAV  = 4'b0110;
  localparam logic [3:0] OP_DIFF  = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, SCAN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic             cpend_q, cpend_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_shift;
  logic             is_diff;
  logic [4:0]       shift_n;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  // Decode of the incoming request; only consumed on the accepting edge.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    sum       = {1'b0, a} + {1'b0, b};
    shift_n   = ALU_control_input[3] ? shamt : b[4:0];
    is_diff   = (ALU_control_input == OP_DIFF);
    is_shift  = 1'b0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (ALU_control_input)
      OP_ADD, OP_ADDI: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_COMP, OP_COMPI: alu_res = ~b + WIDTH'(1);
      OP_AND:            alu_res = a & b;
      OP_XOR:            alu_res = a ^ b;
      OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV: is_shift = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // DONE is the commit cycle; the done pulse appears on the edge leaving it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_diff)                          state_d = SCAN;
          else if (is_shift && shift_n != 5'd0) state_d = SHIFT;
          else                                  state_d = DONE;
        end
      end
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      SCAN:    if (work_q[0] || cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    work_d   = work_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    cpend_d  = cpend_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    busy_d   = (state_q == SHIFT) || (state_q == SCAN);
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          kind_d  = ALU_control_input[1:0];
          cpend_d = alu_carry;
          cnt_d   = '0;
          if (is_diff) begin
            work_d = a ^ b;
          end else if (is_shift) begin
            work_d = a;
            cnt_d  = CNT_W'(shift_n);
          end else begin
            work_d = alu_res;
          end
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        case (kind_q)
          2'b00:   work_d = {work_q[WIDTH-2:0], 1'b0};
          2'b10:   work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
          default: work_d = {1'b0, work_q[WIDTH-1:1]};
        endcase
      end
      SCAN: begin
        // The difference word is consumed LSB-first, so work_q[0] is bit cnt_q of a^b.
        if (work_q[0]) begin
          work_d = WIDTH'(cnt_q);
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          work_d = WIDTH'(WIDTH);
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          work_d = work_q >> 1;
        end
      end
      DONE: begin
        result_d = work_q;
        carry_d  = cpend_q;
        zero_d   = (work_q == '0);
        sign_d   = work_q[WIDTH-1];
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q   <= '0;
      cnt_q    <= '0;
      kind_q   <= '0;
      cpend_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      cpend_q  <= cpend_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign sign   = sign_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model of results and done latency.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        carry;
  logic        zero;
  logic        sign;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] ops [16] = '{4'h0, 4'h8, 4'h1, 4'h9, 4'h2, 4'h3, 4'hC, 4'hD,
                           4'hE, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hF};

  alu_exec_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .ALU_control_input (op),
    .a                 (a),
    .b                 (b),
    .shamt             (shamt),
    .result            (result),
    .carry             (carry),
    .zero              (zero),
    .sign              (sign),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: result, carry and the number of edges from acceptance to the done pulse.
  task automatic model(input logic [3:0] op_m, input logic [31:0] am, input logic [31:0] bm,
                       input logic [4:0] sm, output logic [31:0] r, output logic c,
                       output int lat);
    int          n;
    logic [32:0] s;
    n   = op_m[3] ? int'(sm) : int'(bm[4:0]);
    r   = '0;
    c   = 1'b0;
    lat = 1;
    case (op_m)
      4'h0, 4'h8: begin
        s = {1'b0, am} + {1'b0, bm};
        r = s[31:0];
        c = s[32];
      end
      4'h1, 4'h9: r = 32'd0 - bm;
      4'h2:       r = am & bm;
      4'h3:       r = am ^ bm;
      4'hC, 4'h4: begin r = am << n; lat = 1 + n; end
      4'hD, 4'h5: begin r = am >> n; lat = 1 + n; end
      4'hE, 4'h6: begin r = $unsigned($signed(am) >>> n); lat = 1 + n; end
      4'h7: begin
        r = 32'd32;
        for (int i = 31; i >= 0; i--) if (am[i] != bm[i]) r = 32'(i);
        lat = (r == 32'd32) ? 33 : 2 + int'(r);
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] op_v, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] sv, input string tag);
    logic [31:0] er;
    logic        ec;
    int          el;
    int          lat;
    int          busy_cnt;
    bit          seen;
    model(op_v, av, bv, sv, er, ec, el);
    @(negedge clk);
    op = op_v; a = av; b = bv; shamt = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; shamt = 5'($urandom); op = 4'($urandom);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc;
        check($sformatf("%s busy@done", tag), 32'(busy), 32'd0);
      end else if (busy) begin
        busy_cnt++;
      end
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'(el));
    check($sformatf("%s result", tag), result, er);
    check($sformatf("%s carry", tag), 32'(carry), 32'(ec));
    check($sformatf("%s zero", tag), 32'(zero), 32'(er == 32'd0));
    check($sformatf("%s sign", tag), 32'(sign), 32'(er[31]));
    check($sformatf("%s busy cycles", tag), 32'(busy_cnt), 32'(el - 1));
    @(posedge clk); #1;
    check($sformatf("%s done pulse width", tag), 32'(done), 32'd0);
  endtask

  task automatic test_ignore_busy_start();
    int          ndone;
    int          lat;
    logic [31:0] res;
    logic [31:0] av;
    ndone = 0; lat = 0; res = '0;
    av = $urandom | 32'h8000_0000;
    @(negedge clk);
    op = 4'hD; a = av; b = $urandom; shamt = 5'd31; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin lat = cyc; res = result; end
      end
      if (cyc == 4) begin start = 1'b1; op = 4'h0; a = $urandom; end
      if (cyc == 6) start = 1'b0;
    end
    check("ignore latency", 32'(lat), 32'd32);
    check("ignore result", res, av >> 31);
    check("ignore done count", 32'(ndone), 32'd1);
  endtask

  task automatic test_reset_mid_shift();
    int ndone;
    ndone = 0;
    @(negedge clk);
    op = 4'hD; a = $urandom | 32'h1; b = $urandom; shamt = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", result, 32'd0);
    check("rst done", 32'(done), 32'd0);
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst no late done", 32'(ndone), 32'd0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op = 4'h0; a = 32'h0000_0010; b = 32'h0000_0020; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b first done", 32'(done), 32'd1);
    check("b2b first result", result, 32'h0000_0030);
    op = 4'h1; a = $urandom; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b accept edge done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b second done", 32'(done), 32'd1);
    check("b2b second result", result, 32'hFFFF_FFFB);
    check("b2b second sign", 32'(sign), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", result, 32'd0);
    check("reset carry", 32'(carry), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    check("reset sign", 32'(sign), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, "add wrap");
    run_op(4'hE, 32'h8000_0000, 32'h0, 5'd4, "shra4");
    run_op(4'h4, 32'h0000_1234, 32'hABCD_EF00, 5'd9, "shllv0");
    test_ignore_busy_start();
    run_op(4'h7, 32'h0000_0100, 32'h0, 5'd0, "diff8");
    run_op(4'h7, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 5'd0, "diff equal");
    run_op(4'h7, 32'h8000_0000, 32'h0, 5'd0, "diff msb");
    test_reset_mid_shift();
    run_op(4'h3, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, "xor");
    run_op(4'h1, 32'h1234_5678, 32'h0, 5'd0, "comp zero");
    run_op(4'h9, 32'h0, 32'h8000_0000, 5'd0, "compi min");
    run_op(4'h8, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, "addi overflow");
    run_op(4'hC, 32'hDEAD_BEEF, 32'h0, 5'd31, "shll31");
    run_op(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, "unsupported");
    test_back_to_back();

    for (int it = 0; it < 80; it++) begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = ops[$urandom_range(0, 15)];
      ra  = $urandom;
      rb  = $urandom;
      if (rop == 4'h7) begin
        case ($urandom_range(0, 2))
          0:       rb = ra;
          1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
          default: ;
        endcase
      end
      run_op(rop, ra, rb, 5'($urandom), $sformatf("rnd%0d op%h", it, rop));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
